// File: rtl/seg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {GUARD, SHOW} state_e;

  // Bit k set when digit k (k>0) and every more significant digit are zero.
  function automatic logic [7:0] lz_mask(input logic [31:0] value, input int unsigned digits);
    logic all_zero;
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      if (unsigned'(k) < digits) begin
        all_zero   = all_zero && (value[4*k +: 4] == 4'h0);
        lz_mask[k] = all_zero;
      end
    end
  endfunction

endpackage

// File: rtl/sevenSeg.sv
// Hex-digit to active-low segment decoder, {g,f,e,d,c,b,a}; non-decimal codes are blank.
module sevenSeg
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1011000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with handshake load and frame-aligned commit.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SHOW_CYC  = 50000,
  parameter int unsigned GUARD_CYC = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_req,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  output logic                  load_ack,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  frame_done
);

  localparam int unsigned MaxCyc = (SHOW_CYC > GUARD_CYC) ? SHOW_CYC : GUARD_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc);
  localparam int unsigned IdxW   = $clog2(DIGITS);

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0]   shadow_val_q, disp_val_q, disp_val_d;
  logic                  shadow_blk_q, disp_blk_q, disp_blk_d;
  logic                  pend_q;
  logic                  phase_end, enter_show, commit, capture, blanked;
  logic [3:0]            nib;
  logic [6:0]            dec_seg, seg_d;
  logic [DIGITS-1:0]     an_d;
  logic [7:0]            lz;

  always_comb begin
    phase_end  = (state_q == GUARD) ? (cnt_q == CntW'(GUARD_CYC - 1))
                                    : (cnt_q == CntW'(SHOW_CYC - 1));
    enter_show = (state_q == GUARD) && phase_end;
    state_d    = state_q;
    if (phase_end) state_d = (state_q == GUARD) ? SHOW : GUARD;

    idx_d = idx_q;
    if (enter_show) idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;

    // Commit only when entering digit 0 so a frame never mixes two values.
    commit     = enter_show && (idx_q == IdxW'(DIGITS - 1)) && pend_q;
    disp_val_d = commit ? shadow_val_q : disp_val_q;
    disp_blk_d = commit ? shadow_blk_q : disp_blk_q;
    capture    = load_req && !load_ack;

    // Decode from next-state values so seg lines up with the registered an.
    nib     = disp_val_d[4*idx_d +: 4];
    lz      = lz_mask(32'(disp_val_d), DIGITS);
    blanked = disp_blk_d && lz[idx_d];
    seg_d   = ((state_d == SHOW) && !blanked) ? dec_seg : SEG_BLANK;
    an_d    = '1;
    if (state_d == SHOW) an_d[idx_d] = 1'b0;
  end

  sevenSeg u_dec (
    .digit (nib),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= GUARD;
      cnt_q        <= '0;
      idx_q        <= IdxW'(DIGITS - 1);
      shadow_val_q <= '0;
      shadow_blk_q <= 1'b0;
      pend_q       <= 1'b0;
      disp_val_q   <= '1;
      disp_blk_q   <= 1'b0;
      load_ack     <= 1'b0;
      an           <= '1;
      seg          <= SEG_BLANK;
      frame_done   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
      idx_q      <= idx_d;
      disp_val_q <= disp_val_d;
      disp_blk_q <= disp_blk_d;
      if (capture) begin
        shadow_val_q <= value;
        shadow_blk_q <= blank_lz;
        pend_q       <= 1'b1;
      end else if (commit) begin
        pend_q <= 1'b0;
      end
      load_ack   <= capture;
      an         <= an_d;
      seg        <= seg_d;
      frame_done <= enter_show && (idx_q == IdxW'(DIGITS - 1));
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl against a frame-slot reference model.
module tb_seg_scan_ctrl;

  localparam int Digits = 4;
  localparam int Show   = 4;
  localparam int Guard  = 2;
  localparam int Slot   = Show + Guard;
  localparam int Frame  = Digits * Slot;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_req = 1'b0;
  logic [15:0] value = '0;
  logic        blank_lz = 1'b0;
  logic        load_ack;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          n = 0;
  logic [15:0] m_shadow = '0, m_disp = 16'hFFFF;
  logic        m_sblk = 1'b0, m_dblk = 1'b0, m_pend = 1'b0, m_ack = 1'b0, m_fd = 1'b0;

  seg_scan_ctrl #(.DIGITS(Digits), .SHOW_CYC(Show), .GUARD_CYC(Guard)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .value      (value),
    .blank_lz   (blank_lz),
    .load_ack   (load_ack),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1011000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  // One clock: update the model with the inputs seen at the edge, then check outputs.
  task automatic step();
    int p, sp, d;
    logic show, cap;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    @(posedge clk);
    if (rst) begin
      n = 0; m_pend = 0; m_disp = 16'hFFFF; m_dblk = 0; m_ack = 0; m_fd = 0;
    end else begin
      n++;
      p    = n - 2;
      m_fd = (p >= 0) && (p % Frame == 0);
      cap  = load_req && !m_ack;
      if (m_fd && m_pend) begin
        m_disp = m_shadow; m_dblk = m_sblk; m_pend = 0;
      end
      if (cap) begin
        m_shadow = value; m_sblk = blank_lz; m_pend = 1;
      end
      m_ack = cap;
    end
    #1;
    p    = n - 2;
    sp   = (p >= 0) ? p % Frame : 0;
    d    = sp / Slot;
    show = !rst && (p >= 0) && (sp % Slot < Show);
    exp_an  = show ? ~(4'b0001 << d) : 4'hF;
    exp_seg = 7'h7F;
    if (show && !(m_dblk && d > 0 && (m_disp >> (4 * d)) == 16'h0))
      exp_seg = glyph(4'((m_disp >> (4 * d)) & 16'hF));
    chk("an", 16'(an), 16'(exp_an));
    chk("seg", 16'(seg), 16'(exp_seg));
    chk("load_ack", 16'(load_ack), 16'(m_ack));
    chk("frame_done", 16'(frame_done), 16'(m_fd));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  // Advance until the most recent edge landed on the given frame slot.
  task automatic run_to(input int target);
    for (int i = 0; i < Frame + 4; i++) begin
      if (n >= 2 && (n - 2) % Frame == target) return;
      step();
    end
    chk("run_to_timeout", 16'(n), 16'(target));
  endtask

  task automatic load(input logic [15:0] v, input logic b);
    logic got = 1'b0;
    value = v; blank_lz = b; load_req = 1'b1;
    for (int i = 0; i < 4 && !got; i++) begin
      step();
      got = load_ack;
    end
    chk("ack_seen", 16'(got), 16'h1);
    load_req = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    // Reset and idle: blank display, full scan pattern, frame_done each frame
    run(2);
    rst = 1'b0;
    run(30);

    // Plain value, no blanking
    run_to(8);
    load(16'h1234, 1'b0);
    run(2 * Frame);

    // Leading-zero blanking, including the all-zero case
    load(16'h0070, 1'b1);
    run(2 * Frame);
    load(16'h0000, 1'b1);
    run(2 * Frame);

    // Two requests in one frame: last one wins
    run_to(1);
    load(16'h1111, 1'b0);
    run(3);
    load(16'h2222, 1'b0);
    run(2 * Frame);

    // Request lands on the commit edge: old shadow commits, new one next frame
    run_to(5);
    load(16'h5678, 1'b0);
    run_to(Frame - 1);
    load(16'h9090, 1'b1);
    run(2 * Frame);

    // Reset during digit 2 with a pending value and a live unacked request
    run_to(13);
    load(16'h4321, 1'b0);
    load_req = 1'b1; value = 16'h8888;
    rst = 1'b1;
    step();
    load_req = 1'b0;
    rst = 1'b0;
    run(Frame + 4);
    load(16'h0305, 1'b1);
    run(2 * Frame);

    // Randomized loads at random phases
    for (int t = 0; t < 20; t++) begin
      run($urandom_range(0, 30));
      v = '0;
      for (int k = 0; k < 4; k++)
        v[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      load(v, 1'($urandom_range(0, 1)));
    end
    run(2 * Frame);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
